// File: rtl/div_unit.sv
// Multi-cycle restoring divider serving DIV/DIVU from the EX stage.
// result_o = {remainder, quotient}; one quotient bit per cycle on magnitudes, sign fixup at the end.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

  state_t                r_state, w_state;
  logic [CNT_W-1:0]      r_cnt, w_cnt;
  logic [DATA_W-1:0]     r_dvd, w_dvd;
  logic [DATA_W-1:0]     r_dvs, w_dvs;
  logic [DATA_W-1:0]     r_rem, w_rem;
  logic                  r_signed, w_signed;
  logic                  r_sign_a, w_sign_a;
  logic                  r_sign_b, w_sign_b;
  logic [2*DATA_W-1:0]   r_result, w_result;
  logic                  r_ready, w_ready;

  logic [DATA_W:0]       w_trial;
  logic                  w_no_borrow;
  logic [DATA_W-1:0]     w_quo_fix;
  logic [DATA_W-1:0]     w_rem_fix;

  // r_dvd doubles as the quotient register: dividend bits shift out the top, quotient bits in the bottom
  assign w_trial     = {r_rem, r_dvd[DATA_W-1]} - {1'b0, r_dvs};
  assign w_no_borrow = ~w_trial[DATA_W];
  assign w_quo_fix   = (r_signed && (r_sign_a ^ r_sign_b)) ? -r_dvd : r_dvd;
  assign w_rem_fix   = (r_signed && r_sign_a) ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FREE;
      r_cnt    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_signed <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_dvd    <= w_dvd;
      r_dvs    <= w_dvs;
      r_rem    <= w_rem;
      r_signed <= w_signed;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_result <= w_result;
      r_ready  <= w_ready;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_dvd    = r_dvd;
    w_dvs    = r_dvs;
    w_rem    = r_rem;
    w_signed = r_signed;
    w_sign_a = r_sign_a;
    w_sign_b = r_sign_b;
    w_result = r_result;
    w_ready  = r_ready;

    case (r_state)
      S_FREE: begin
        if (start_i && !annul_i) begin
          w_signed = signed_div_i;
          w_sign_a = signed_div_i & opdata1_i[DATA_W-1];
          w_sign_b = signed_div_i & opdata2_i[DATA_W-1];
          w_dvd    = w_sign_a ? -opdata1_i : opdata1_i;
          w_dvs    = w_sign_b ? -opdata2_i : opdata2_i;
          w_rem    = '0;
          w_cnt    = '0;
          w_state  = (opdata2_i == '0) ? S_BYZERO : S_ON;
        end
      end

      S_BYZERO: begin
        w_state  = S_END;
        w_result = '0;
        w_ready  = 1'b1;
      end

      S_ON: begin
        if (annul_i) begin
          w_state  = S_FREE;
          w_cnt    = '0;
          w_result = '0;
          w_ready  = 1'b0;
        end else if (r_cnt == CNT_W'(DATA_W)) begin
          w_state  = S_END;
          w_result = {w_rem_fix, w_quo_fix};
          w_ready  = 1'b1;
        end else begin
          w_rem = w_no_borrow ? w_trial[DATA_W-1:0] : {r_rem[DATA_W-2:0], r_dvd[DATA_W-1]};
          w_dvd = {r_dvd[DATA_W-2:0], w_no_borrow};
          w_cnt = r_cnt + CNT_W'(1);
        end
      end

      S_END: begin
        if (!start_i) begin
          w_state  = S_FREE;
          w_result = '0;
          w_ready  = 1'b0;
        end
      end

      default: begin
        w_state  = S_FREE;
        w_result = '0;
        w_ready  = 1'b0;
      end
    endcase
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  div_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {remainder, quotient}; truncating division, remainder follows dividend sign, x/0 -> 0
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {32'(r), 32'(q)};
  endfunction

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
    logic [63:0] exp;
    int          lat;
    bit          seen;
    bit          leak;
    exp = ref_div(sgn, a, b);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    annul_i      = 1'b0;
    @(posedge clk); #1;
    lat  = 0;
    seen = 1'b0;
    leak = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      opdata1_i    = $urandom;
      opdata2_i    = $urandom;
      signed_div_i = 1'($urandom);
      @(posedge clk); #1;
      lat++;
      if (ready_o) seen = 1'b1;
      else if (result_o !== 64'd0) leak = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), (b == 32'd0) ? 64'd1 : 64'd33);
    check({tag, "_result"}, result_o, exp);
    check({tag, "_idle_res_zero"}, 64'(leak), 64'd0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    check({tag, "_held"}, {result_o[62:0], ready_o}, {exp[62:0], 1'b1});
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop_ready"}, 64'(ready_o), 64'd0);
    check({tag, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    bit          bad;
    logic        s;
    logic [31:0] a, b;

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 3, "u100_7");
    check("u100_7_model", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1, "s_m7_2");
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 2, "s_7_m2");
    run_div(1'b0, 32'hFFFF_FFF9, 32'd2, 0, "u_big_2");
    run_div(1'b0, 32'd5, 32'd0, 2, "u_byzero");
    run_div(1'b1, 32'd5, 32'd0, 2, "s_byzero");
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "s_ovf");
    run_div(1'b1, 32'h8000_0000, 32'h8000_0000, 0, "s_min_min");
    run_div(1'b0, 32'd3, 32'hFFFF_FFFF, 0, "u_small_big");

    // annul at E10 abandons the request; nothing may appear afterwards
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (ready_o !== 1'b0 || result_o !== 64'd0) bad = 1'b1;
    end
    check("annul_quiet", 64'(bad), 64'd0);
    run_div(1'b0, 32'd9, 32'd3, 1, "after_annul");

    // synchronous reset mid-divide at E15
    @(negedge clk);
    signed_div_i = 1'b1;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(posedge clk); #1;
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div(1'b1, 32'd1000, 32'hFFFF_FFFD, 1, "after_rst");

    // random operands, mixing small divisors, zero divisors and sign extremes
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(1, 15));
        1: b = (i % 8 == 0) ? 32'd0 : $urandom;
        2: b = -32'($urandom_range(1, 300));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(s, a, b, $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
